// File: rtl/gpr_fwd_pkg.sv
// Shared types and constants for the GPR forwarding / long-op scoreboard slice.
package gpr_fwd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sb_state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/gpr_fwd_port_mux.sv
// One ID read port: youngest-first stage scan, then long-unit completion, then register file.
module gpr_fwd_port_mux
  import gpr_fwd_pkg::*;
#(
  parameter int unsigned NUM_FWD_STAGES = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5
) (
  input  logic [ADDR_W-1:0]                raddr,
  input  logic [DATA_W-1:0]                rdata,
  input  logic [NUM_FWD_STAGES-1:0]        stg_we,
  input  logic [NUM_FWD_STAGES-1:0]        stg_ready,
  input  logic [NUM_FWD_STAGES*ADDR_W-1:0] stg_waddr,
  input  logic [NUM_FWD_STAGES*DATA_W-1:0] stg_wdata,
  input  logic                             long_fwd,
  input  logic [ADDR_W-1:0]                long_waddr,
  input  logic [DATA_W-1:0]                long_wdata,
  output logic [DATA_W-1:0]                data,
  output logic                             stall_raw
);

  logic found;

  always_comb begin
    data      = rdata;
    stall_raw = 1'b0;
    found     = 1'b0;
    if (raddr != ADDR_W'(REG_ZERO)) begin
      // First match wins; older stages are shadowed even when the match is not ready.
      for (int unsigned s = 0; s < NUM_FWD_STAGES; s++) begin
        if (!found && stg_we[s] && (stg_waddr[s*ADDR_W +: ADDR_W] == raddr)) begin
          found = 1'b1;
          if (stg_ready[s]) data = stg_wdata[s*DATA_W +: DATA_W];
          else              stall_raw = 1'b1;
        end
      end
      if (!found && long_fwd && (long_waddr == raddr)) data = long_wdata;
    end
  end

endmodule

// File: rtl/gpr_forward_scoreboard.sv
// GPR bypass/hazard unit with a one-entry long-latency scoreboard and saturating stall counter.
module gpr_forward_scoreboard
  import gpr_fwd_pkg::*;
#(
  parameter int unsigned NUM_RPORTS     = 2,
  parameter int unsigned NUM_FWD_STAGES = 3,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_ID_valid,
  input  logic [NUM_RPORTS*ADDR_W-1:0]     i_ID_raddr,
  input  logic [NUM_RPORTS*DATA_W-1:0]     i_ID_rdata,
  input  logic                             i_ID_we,
  input  logic [ADDR_W-1:0]                i_ID_waddr,
  input  logic                             i_ID_long_issue,
  input  logic [NUM_FWD_STAGES-1:0]        i_STG_we,
  input  logic [NUM_FWD_STAGES-1:0]        i_STG_ready,
  input  logic [NUM_FWD_STAGES*ADDR_W-1:0] i_STG_waddr,
  input  logic [NUM_FWD_STAGES*DATA_W-1:0] i_STG_wdata,
  input  logic                             i_LONG_done,
  input  logic [DATA_W-1:0]                i_LONG_wdata,
  output logic [NUM_RPORTS*DATA_W-1:0]     o_ID_valid_rdata,
  output logic                             o_ID_stall,
  output logic                             o_LONG_busy,
  output logic [ADDR_W-1:0]                o_LONG_waddr,
  output logic [CNT_W-1:0]                 o_stall_cnt
);

  sb_state_t             state_q, state_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic                  sb_busy;
  logic                  long_fwd;
  logic                  sb_pending;
  logic                  waddr_live;
  logic [NUM_RPORTS-1:0] port_raw;
  logic                  rd_hit;
  logic                  stall_raw, stall_sb_raw, stall_waw, stall_struct;
  logic                  issue_ok;

  // Combinational logic treats the entry as empty while reset is held.
  assign sb_busy    = (state_q == BUSY) && !reset;
  assign long_fwd   = i_LONG_done && sb_busy;
  assign sb_pending = sb_busy && !i_LONG_done;
  assign waddr_live = (waddr_q != ADDR_W'(REG_ZERO));

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    gpr_fwd_port_mux #(
      .NUM_FWD_STAGES(NUM_FWD_STAGES),
      .DATA_W        (DATA_W),
      .ADDR_W        (ADDR_W)
    ) u_mux (
      .raddr     (i_ID_raddr[p*ADDR_W +: ADDR_W]),
      .rdata     (i_ID_rdata[p*DATA_W +: DATA_W]),
      .stg_we    (i_STG_we),
      .stg_ready (i_STG_ready),
      .stg_waddr (i_STG_waddr),
      .stg_wdata (i_STG_wdata),
      .long_fwd  (long_fwd),
      .long_waddr(waddr_q),
      .long_wdata(i_LONG_wdata),
      .data      (o_ID_valid_rdata[p*DATA_W +: DATA_W]),
      .stall_raw (port_raw[p])
    );
  end

  always_comb begin
    rd_hit = 1'b0;
    for (int unsigned p = 0; p < NUM_RPORTS; p++) begin
      if (i_ID_raddr[p*ADDR_W +: ADDR_W] == waddr_q) rd_hit = 1'b1;
    end
  end

  assign stall_raw    = i_ID_valid && (|port_raw);
  assign stall_sb_raw = i_ID_valid && sb_pending && waddr_live && rd_hit;
  assign stall_waw    = i_ID_valid && sb_pending && waddr_live && i_ID_we && (i_ID_waddr == waddr_q);
  assign stall_struct = i_ID_valid && sb_pending && i_ID_long_issue;
  assign o_ID_stall   = stall_raw | stall_sb_raw | stall_waw | stall_struct;
  assign issue_ok     = i_ID_long_issue && !o_ID_stall;

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    unique case (state_q)
      IDLE: begin
        if (issue_ok) begin
          state_d = BUSY;
          waddr_d = i_ID_waddr;
        end
      end
      BUSY: begin
        if (i_LONG_done) begin
          if (issue_ok) waddr_d = i_ID_waddr;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      o_stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      if (o_ID_stall && (o_stall_cnt != '1)) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

  assign o_LONG_busy  = (state_q == BUSY);
  assign o_LONG_waddr = waddr_q;

endmodule

// File: tb/tb_gpr_forward_scoreboard.sv
// Directed bench for gpr_forward_scoreboard: vector table for forwarding, sequences for the scoreboard.
module tb_gpr_forward_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_ID_valid;
  logic [9:0]  i_ID_raddr;
  logic [63:0] i_ID_rdata;
  logic        i_ID_we;
  logic [4:0]  i_ID_waddr;
  logic        i_ID_long_issue;
  logic [2:0]  i_STG_we, i_STG_ready;
  logic [14:0] i_STG_waddr;
  logic [95:0] i_STG_wdata;
  logic        i_LONG_done;
  logic [31:0] i_LONG_wdata;

  logic [63:0] rdata_a, rdata_b;
  logic        stall_a, stall_b, busy_a, busy_b;
  logic [4:0]  lwa_a, lwa_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  gpr_forward_scoreboard #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .i_ID_valid(i_ID_valid), .i_ID_raddr(i_ID_raddr),
    .i_ID_rdata(i_ID_rdata), .i_ID_we(i_ID_we), .i_ID_waddr(i_ID_waddr),
    .i_ID_long_issue(i_ID_long_issue), .i_STG_we(i_STG_we), .i_STG_ready(i_STG_ready),
    .i_STG_waddr(i_STG_waddr), .i_STG_wdata(i_STG_wdata), .i_LONG_done(i_LONG_done),
    .i_LONG_wdata(i_LONG_wdata), .o_ID_valid_rdata(rdata_a), .o_ID_stall(stall_a),
    .o_LONG_busy(busy_a), .o_LONG_waddr(lwa_a), .o_stall_cnt(cnt_a)
  );

  gpr_forward_scoreboard #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .i_ID_valid(i_ID_valid), .i_ID_raddr(i_ID_raddr),
    .i_ID_rdata(i_ID_rdata), .i_ID_we(i_ID_we), .i_ID_waddr(i_ID_waddr),
    .i_ID_long_issue(i_ID_long_issue), .i_STG_we(i_STG_we), .i_STG_ready(i_STG_ready),
    .i_STG_waddr(i_STG_waddr), .i_STG_wdata(i_STG_wdata), .i_LONG_done(i_LONG_done),
    .i_LONG_wdata(i_LONG_wdata), .o_ID_valid_rdata(rdata_b), .o_ID_stall(stall_b),
    .o_LONG_busy(busy_b), .o_LONG_waddr(lwa_b), .o_stall_cnt(cnt_b)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  ra0, ra1;
    logic [31:0] rd0, rd1;
    logic [2:0]  we, rdy;
    logic [14:0] wa;
    logic [95:0] wd;
    logic        c0, c1;
    logic [31:0] e0, e1;
    logic        es;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic idle_in();
    i_ID_valid = 0; i_ID_raddr = '0; i_ID_rdata = '0; i_ID_we = 0; i_ID_waddr = '0;
    i_ID_long_issue = 0; i_STG_we = '0; i_STG_ready = '0; i_STG_waddr = '0;
    i_STG_wdata = '0; i_LONG_done = 0; i_LONG_wdata = '0;
  endtask

  // Checks stall before the edge, then both counters after it.
  task automatic cyc(input string nm, input logic es);
    #1;
    chk({nm, "_stall"}, {31'd0, stall_a}, {31'd0, es});
    if (es) exp_cnt++;
    @(posedge clk); #1;
    chk({nm, "_cnt"}, cnt_a, exp_cnt);
    chk({nm, "_cnt4"}, {28'd0, cnt_b}, (exp_cnt > 15) ? 32'd15 : exp_cnt);
  endtask

  task automatic ports(input logic [4:0] r0, input logic [4:0] r1);
    i_ID_raddr = {r1, r0};
    i_ID_rdata = {32'hB2B2_0001, 32'hA1A1_0000};
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd1, 5'd2, 32'hA1, 32'hA2, 3'b000, 3'b000, 15'd0, 96'd0,
                1'b1, 1'b1, 32'hA1, 32'hA2, 1'b0};
    vecs[1] = '{1'b1, 5'd3, 5'd4, 32'hA1, 32'hA2, 3'b011, 3'b011, {5'd0, 5'd3, 5'd3},
                {32'h0, 32'h22, 32'h11}, 1'b1, 1'b1, 32'h11, 32'hA2, 1'b0};
    vecs[2] = '{1'b1, 5'd1, 5'd5, 32'hA1, 32'hA2, 3'b001, 3'b000, {5'd0, 5'd0, 5'd5},
                {32'h0, 32'h0, 32'h55}, 1'b1, 1'b0, 32'hA1, 32'h0, 1'b1};
    vecs[3] = '{1'b1, 5'd3, 5'd3, 32'hA1, 32'hA2, 3'b110, 3'b110, {5'd3, 5'd3, 5'd3},
                {32'h33, 32'h22, 32'h11}, 1'b1, 1'b1, 32'h22, 32'h22, 1'b0};
    vecs[4] = '{1'b1, 5'd6, 5'd2, 32'hA1, 32'hA2, 3'b011, 3'b001, {5'd0, 5'd6, 5'd6},
                {32'h0, 32'hBAD, 32'h66}, 1'b1, 1'b1, 32'h66, 32'hA2, 1'b0};
    vecs[5] = '{1'b0, 5'd7, 5'd7, 32'hA1, 32'hA2, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7},
                {32'h0, 32'h0, 32'h77}, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[6] = '{1'b1, 5'd0, 5'd0, 32'h5A, 32'h5B, 3'b111, 3'b000, 15'd0,
                {32'h33, 32'h22, 32'h11}, 1'b1, 1'b1, 32'h5A, 32'h5B, 1'b0};
    vecs[7] = '{1'b1, 5'd8, 5'd9, 32'hA1, 32'hA2, 3'b110, 3'b110, {5'd9, 5'd8, 5'd0},
                {32'h99, 32'h88, 32'h0}, 1'b1, 1'b1, 32'h88, 32'h99, 1'b0};

    idle_in();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_waddr", {27'd0, lwa_a}, 32'd0);
    chk("rst_cnt", cnt_a, 32'd0);
    @(negedge clk); reset = 0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_in();
      i_ID_valid = vecs[i].valid;
      i_ID_raddr = {vecs[i].ra1, vecs[i].ra0};
      i_ID_rdata = {vecs[i].rd1, vecs[i].rd0};
      i_STG_we = vecs[i].we; i_STG_ready = vecs[i].rdy;
      i_STG_waddr = vecs[i].wa; i_STG_wdata = vecs[i].wd;
      #1;
      if (vecs[i].c0) chk($sformatf("vec%0d_d0", i), rdata_a[31:0], vecs[i].e0);
      if (vecs[i].c1) chk($sformatf("vec%0d_d1", i), rdata_a[63:32], vecs[i].e1);
      cyc($sformatf("vec%0d", i), vecs[i].es);
    end

    // Long op to r7, three blocked reads, then completion forwarding.
    @(negedge clk); idle_in(); i_ID_valid = 1; i_ID_long_issue = 1; i_ID_waddr = 5'd7;
    cyc("issue7", 1'b0);
    chk("issue7_busy", {31'd0, busy_a}, 32'd1);
    chk("issue7_waddr", {27'd0, lwa_a}, 32'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle_in(); i_ID_valid = 1; ports(5'd1, 5'd7);
      cyc($sformatf("sbraw%0d", i), 1'b1);
    end
    @(negedge clk); idle_in(); i_ID_valid = 1; ports(5'd7, 5'd2);
    i_LONG_done = 1; i_LONG_wdata = 32'hDEAD;
    #1;
    chk("done_fwd", rdata_a[31:0], 32'hDEAD);
    chk("done_other", rdata_a[63:32], 32'hB2B2_0001);
    cyc("done", 1'b0);
    chk("done_idle", {31'd0, busy_a}, 32'd0);
    @(negedge clk); idle_in(); i_ID_valid = 1; ports(5'd7, 5'd2);
    i_LONG_done = 1; i_LONG_wdata = 32'hBEEF;
    #1;
    chk("idle_done_nofwd", rdata_a[31:0], 32'hA1A1_0000);
    cyc("idle_done", 1'b0);

    // WAW, structural, then back-to-back issue on completion.
    @(negedge clk); idle_in(); i_ID_valid = 1; i_ID_long_issue = 1; i_ID_waddr = 5'd7;
    cyc("issue7b", 1'b0);
    @(negedge clk); idle_in(); i_ID_valid = 1; i_ID_we = 1; i_ID_waddr = 5'd7; ports(5'd1, 5'd2);
    cyc("waw", 1'b1);
    @(negedge clk); idle_in(); i_ID_valid = 1; i_ID_long_issue = 1; i_ID_waddr = 5'd9;
    cyc("struct", 1'b1);
    chk("struct_waddr", {27'd0, lwa_a}, 32'd7);
    @(negedge clk); idle_in(); i_ID_valid = 1; i_ID_long_issue = 1; i_ID_waddr = 5'd9;
    i_LONG_done = 1;
    cyc("b2b", 1'b0);
    chk("b2b_busy", {31'd0, busy_a}, 32'd1);
    chk("b2b_waddr", {27'd0, lwa_a}, 32'd9);

    // Reset while busy drops the entry; a late done is ignored.
    @(negedge clk); idle_in(); reset = 1;
    @(posedge clk); #1;
    exp_cnt = 0;
    chk("rstmid_busy", {31'd0, busy_a}, 32'd0);
    chk("rstmid_cnt", cnt_a, 32'd0);
    @(negedge clk); idle_in(); reset = 0; i_ID_valid = 1; ports(5'd9, 5'd2);
    i_LONG_done = 1; i_LONG_wdata = 32'hCAFE;
    #1;
    chk("rstmid_nofwd", rdata_a[31:0], 32'hA1A1_0000);
    cyc("rstmid_done", 1'b0);
    chk("rstmid_idle", {31'd0, busy_a}, 32'd0);

    // Destination r0 occupies the entry but never creates a hazard.
    @(negedge clk); idle_in(); i_ID_valid = 1; i_ID_long_issue = 1; i_ID_waddr = 5'd0;
    cyc("issue0", 1'b0);
    chk("issue0_busy", {31'd0, busy_a}, 32'd1);
    @(negedge clk); idle_in(); i_ID_valid = 1; i_ID_we = 1; i_ID_waddr = 5'd0; ports(5'd0, 5'd0);
    cyc("r0_nohaz", 1'b0);
    @(negedge clk); idle_in(); i_LONG_done = 1;
    cyc("r0_done", 1'b0);

    // Counter saturation on the 4-bit build.
    @(negedge clk); idle_in(); reset = 1;
    @(posedge clk); #1; exp_cnt = 0;
    @(negedge clk); reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); idle_in(); i_ID_valid = 1; ports(5'd1, 5'd5);
      i_STG_we = 3'b001; i_STG_waddr = {5'd0, 5'd0, 5'd5};
      cyc($sformatf("sat%0d", i), 1'b1);
    end
    chk("sat_cnt4_final", {28'd0, cnt_b}, 32'd15);
    chk("sat_cnt32_final", cnt_a, 32'd20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
